// File: rtl/mmio_timer_device.sv
// Memory-mapped timer peripheral: reloadable 32-bit timer with sticky interrupt,
// free-running SysTick, LED and 7-segment digit registers behind a 32-byte window.
module mmio_timer_device #(
  parameter logic [31:0] BASE_ADDR   = 32'h40000000,
  parameter int          LED_WIDTH   = 8,
  parameter int          DIGIT_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [31:0]            MemBus_Address,
  input  logic [31:0]            MemBus_Write_Data,
  output logic [31:0]            Device_Read_Data,
  output logic                   dev_hit,
  output logic [LED_WIDTH-1:0]   leds,
  output logic [DIGIT_WIDTH-1:0] digits,
  output logic                   irq
);

  localparam logic [2:0] IDX_TH    = 3'd0;
  localparam logic [2:0] IDX_TL    = 3'd1;
  localparam logic [2:0] IDX_TCON  = 3'd2;
  localparam logic [2:0] IDX_LED   = 3'd3;
  localparam logic [2:0] IDX_DIGIT = 3'd4;
  localparam logic [2:0] IDX_TICK  = 3'd5;

  logic [31:0]            th_q, th_d, tl_q, tl_d, tick_q, tick_d;
  logic [2:0]             tcon_q, tcon_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic [DIGIT_WIDTH-1:0] digit_q, digit_d;
  logic [2:0]             idx;
  logic                   in_win, wr_en, ovf, ovf_flag;
  logic                   unused_addr;

  assign idx         = MemBus_Address[4:2];
  assign in_win      = (MemBus_Address[31:5] == BASE_ADDR[31:5]);
  assign dev_hit     = in_win && (idx <= IDX_TICK);
  assign wr_en       = MemWrite && dev_hit;
  assign ovf         = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_flag    = ovf && tcon_q[1];
  assign unused_addr = ^MemBus_Address[1:0];

  always_comb begin
    Device_Read_Data = 32'h0;
    if (MemRead && dev_hit) begin
      case (idx)
        IDX_TH:    Device_Read_Data = th_q;
        IDX_TL:    Device_Read_Data = tl_q;
        IDX_TCON:  Device_Read_Data = 32'(tcon_q);
        IDX_LED:   Device_Read_Data = 32'(led_q);
        IDX_DIGIT: Device_Read_Data = 32'(digit_q);
        IDX_TICK:  Device_Read_Data = tick_q;
        default:   Device_Read_Data = 32'h0;
      endcase
    end
  end

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    tcon_d  = tcon_q;
    led_d   = led_q;
    digit_d = digit_q;
    tick_d  = tick_q + 32'd1;

    if (tcon_q[0]) tl_d = ovf ? th_q : tl_q + 32'd1;
    if (ovf_flag)  tcon_d[2] = 1'b1;

    // Software writes override hardware updates, except a flagged overflow
    // always leaves the status bit set in the same cycle.
    if (wr_en) begin
      case (idx)
        IDX_TH:    th_d    = MemBus_Write_Data;
        IDX_TL:    tl_d    = MemBus_Write_Data;
        IDX_TCON:  tcon_d  = MemBus_Write_Data[2:0] | {ovf_flag, 2'b00};
        IDX_LED:   led_d   = MemBus_Write_Data[LED_WIDTH-1:0];
        IDX_DIGIT: digit_d = MemBus_Write_Data[DIGIT_WIDTH-1:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q    <= '0;
      tl_q    <= '0;
      tcon_q  <= '0;
      led_q   <= '0;
      digit_q <= '0;
      tick_q  <= '0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      tcon_q  <= tcon_d;
      led_q   <= led_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
    end
  end

  assign leds   = led_q;
  assign digits = digit_q;
  assign irq    = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_mmio_timer_device.sv
// Bench for mmio_timer_device: register-array reference model checked every
// cycle, directed scenarios with literal expectations, then random bus traffic.
module tb_mmio_timer_device;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk, reset, MemRead, MemWrite;
  logic [31:0] MemBus_Address, MemBus_Write_Data, Device_Read_Data;
  logic        dev_hit, irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  mmio_timer_device #(.BASE_ADDR(BASE), .LED_WIDTH(8), .DIGIT_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
    .Device_Read_Data(Device_Read_Data), .dev_hit(dev_hit),
    .leds(leds), .digits(digits), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: six registers 0 TH, 1 TL, 2 TCON, 3 LED, 4 DIGIT, 5 SysTick
  logic [31:0] m_reg [6] = '{default: 32'h0};
  logic [31:0] mask  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'hFF, 32'hFFF, 32'hFFFFFFFF};

  function automatic logic exp_hit(input logic [31:0] a);
    return ((a >> 5) == (BASE >> 5)) && ((a & 32'd31) < 32'd24);
  endfunction

  function automatic logic [31:0] exp_read(input logic r, input logic [31:0] a);
    if (!r || !exp_hit(a)) return 32'h0;
    return m_reg[(a & 32'd31) / 4];
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [31:0] nx [6];
    logic        wrap, flagged;
    int          k;
    if (reset) begin
      for (int i = 0; i < 6; i++) m_reg[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 6; i++) nx[i] = m_reg[i];
      wrap    = m_reg[2][0] && (m_reg[1] == 32'hFFFFFFFF);
      flagged = wrap && m_reg[2][1];
      nx[5] = m_reg[5] + 1;
      if (m_reg[2][0]) nx[1] = wrap ? m_reg[0] : m_reg[1] + 1;
      if (flagged) nx[2] = nx[2] | 32'h4;
      if (MemWrite && exp_hit(MemBus_Address)) begin
        k = int'((MemBus_Address & 32'd31) / 4);
        if (k != 5) nx[k] = MemBus_Write_Data & mask[k];
        if (k == 2 && flagged) nx[2] = nx[2] | 32'h4;
      end
      for (int i = 0; i < 6; i++) m_reg[i] <= nx[i];
    end
  end

  always @(negedge clk) begin
    chk("dev_hit", {31'h0, dev_hit}, {31'h0, exp_hit(MemBus_Address)});
    chk("rdata", Device_Read_Data, exp_read(MemRead, MemBus_Address));
    chk("leds", {24'h0, leds}, m_reg[3]);
    chk("digits", {20'h0, digits}, m_reg[4]);
    chk("irq", {31'h0, irq}, {31'h0, m_reg[2][1] & m_reg[2][2]});
  end

  logic [31:0] s_rd;
  logic        s_hit, s_irq;
  logic [7:0]  s_leds;
  logic [11:0] s_dig;

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    MemRead = r; MemWrite = w; MemBus_Address = a; MemBus_Write_Data = d;
    @(negedge clk);
    s_rd = Device_Read_Data; s_hit = dev_hit; s_irq = irq; s_leds = leds; s_dig = digits;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          ix;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    MemBus_Address = 32'h0; MemBus_Write_Data = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset, then SysTick and cleared registers
    repeat (10) bus(0, 0, 32'h0, 32'h0);
    bus(1, 0, BASE + 20, 0); chk("tick10", s_rd, 32'd10);
    chk("rst_leds", {24'h0, s_leds}, 32'h0);
    chk("rst_digits", {20'h0, s_dig}, 32'h0);
    chk("rst_irq", {31'h0, s_irq}, 32'h0);
    bus(1, 0, BASE + 0, 0); chk("rst_th", s_rd, 32'h0);
    bus(1, 0, BASE + 4, 0); chk("rst_tl", s_rd, 32'h0);
    bus(1, 0, BASE + 8, 0); chk("rst_tcon", s_rd, 32'h0);

    // LED / DIGIT truncation
    bus(0, 1, BASE + 12, 32'h1A5);
    bus(0, 1, BASE + 16, 32'hABCD);
    bus(1, 0, BASE + 12, 0);
    chk("led_rd", s_rd, 32'hA5);
    chk("leds_pin", {24'h0, s_leds}, 32'hA5);
    chk("digits_pin", {20'h0, s_dig}, 32'hBCD);
    bus(1, 0, BASE + 16, 0); chk("digit_rd", s_rd, 32'hBCD);

    // Timer count, overflow reload, sticky status
    bus(0, 1, BASE + 0, 32'hFFFFFFFC);
    bus(0, 1, BASE + 4, 32'hFFFFFFFE);
    bus(0, 1, BASE + 8, 32'h3);
    bus(1, 0, BASE + 4, 0); chk("tl_c0", s_rd, 32'hFFFFFFFE);
    bus(1, 0, BASE + 4, 0); chk("tl_c1", s_rd, 32'hFFFFFFFF);
    bus(1, 0, BASE + 4, 0); chk("tl_reload", s_rd, 32'hFFFFFFFC);
    bus(1, 0, BASE + 8, 0); chk("tcon_set", s_rd, 32'h7);
    chk("irq_set", {31'h0, s_irq}, 32'h1);
    bus(1, 0, BASE + 4, 0);
    bus(1, 0, BASE + 4, 0);
    bus(1, 0, BASE + 4, 0); chk("tl_reload2", s_rd, 32'hFFFFFFFC);

    // Clear status off-overflow, then attempt a clear on the overflow cycle
    bus(0, 1, BASE + 8, 32'h3);
    bus(1, 0, BASE + 8, 0); chk("tcon_clr", s_rd, 32'h3);
    chk("irq_clr", {31'h0, s_irq}, 32'h0);
    bus(0, 1, BASE + 8, 32'h3);
    bus(1, 0, BASE + 8, 0); chk("tcon_hwwin", s_rd, 32'h7);
    chk("irq_hwwin", {31'h0, s_irq}, 32'h1);

    // Decode boundaries
    bus(1, 0, BASE + 24, 0);
    chk("hit_unmapped", {31'h0, s_hit}, 32'h0); chk("rd_unmapped", s_rd, 32'h0);
    bus(1, 0, 32'h50000000, 0);
    chk("hit_outside", {31'h0, s_hit}, 32'h0); chk("rd_outside", s_rd, 32'h0);
    bus(0, 1, BASE + 20, 32'h1234);
    chk("hit_tick_wr", {31'h0, s_hit}, 32'h1);
    bus(1, 0, BASE + 20, 0);
    bus(0, 0, BASE + 12, 0);
    chk("rd_no_strobe", s_rd, 32'h0); chk("hit_no_strobe", {31'h0, s_hit}, 32'h1);

    // Random traffic; model comparison runs every cycle
    for (int n = 0; n < 800; n++) begin
      ix = $urandom_range(0, 7);
      a  = BASE + 32'(ix * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(5, 31));
      case (ix)
        1:       d = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        2:       d = $urandom_range(0, 1) ? ($urandom | 32'h1) : $urandom;
        default: d = $urandom;
      endcase
      bus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d);
    end

    // Async reset while the timer runs with irq asserted
    bus(0, 1, BASE + 8, 32'h0);
    bus(0, 1, BASE + 0, 32'h0);
    bus(0, 1, BASE + 4, 32'hFFFFFFFE);
    bus(0, 1, BASE + 12, 32'h5A);
    bus(0, 1, BASE + 8, 32'h3);
    repeat (3) bus(0, 0, 32'h0, 32'h0);
    chk("irq_before_rst", {31'h0, irq}, 32'h1);
    MemRead = 1'b1; MemBus_Address = BASE + 8;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_irq", {31'h0, irq}, 32'h0);
    chk("rst_async_leds", {24'h0, leds}, 32'h0);
    chk("rst_async_tcon", Device_Read_Data, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    MemRead = 1'b0;
    bus(1, 0, BASE + 20, 0); chk("tick_restart0", s_rd, 32'h0);
    bus(1, 0, BASE + 20, 0); chk("tick_restart1", s_rd, 32'h1);
    bus(1, 0, BASE + 4, 0);  chk("tl_after_rst", s_rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
